// File: rtl/ifu_fetch.sv
// ifu_fetch: instruction-fetch stage. Owns the architectural PC, fetches words
// from instruction memory over a req/ack handshake, and loads the IF/ID latch.
// A one-entry skid buffer absorbs a stall that lands on the ack cycle. A flush
// redirects the PC; if it arrives while a fetch is unacked, the request is
// drained first.
// Optional feature macro: FETCH_ALIGN_CHECK_EN. When it is defined, a misaligned
// PC is not fetched. It completes internally as a nop tagged with id_exc_adel.
module ifu_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] npc_in,
    input  logic        stall,
    input  logic        flush,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc,
    output logic        id_valid,
    output logic [31:0] id_pc,
    output logic [31:0] id_instr,
    output logic        id_exc_adel
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_HOLD  = 2'd1,
        S_DRAIN = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] redir_q, redir_d;
    logic [31:0] skid_instr_q, skid_instr_d;
    logic        skid_exc_q, skid_exc_d;
    logic        id_valid_q, id_valid_d;
    logic [31:0] id_pc_q, id_pc_d;
    logic [31:0] id_instr_q, id_instr_d;
    logic        id_exc_q, id_exc_d;

    logic        misaligned;
    logic        fetch_done;
    logic [31:0] fetch_instr;
    logic        fetch_exc;

`ifdef FETCH_ALIGN_CHECK_EN
    assign misaligned = (state_q == S_FETCH) && (pc_q[1:0] != 2'b00);
    assign imem_addr  = pc_q;
`else
    assign misaligned = 1'b0;
    assign imem_addr  = {pc_q[31:2], 2'b00};
`endif

    // A fetch completes on ack, or internally when the PC is misaligned.
    assign fetch_done  = (state_q == S_FETCH) && (misaligned || imem_ack);
    assign fetch_instr = misaligned ? 32'h0 : imem_rdata;
    assign fetch_exc   = misaligned;

    assign pc          = pc_q;
    assign id_valid    = id_valid_q;
    assign id_pc       = id_pc_q;
    assign id_instr    = id_instr_q;
    assign id_exc_adel = id_exc_q;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. Flush outranks stall.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH: begin
                if (fetch_done) begin
                    if (!flush && stall) begin
                        state_d = S_HOLD;
                    end
                end else if (flush) begin
                    state_d = S_DRAIN;
                end
            end
            S_HOLD: begin
                if (flush || !stall) begin
                    state_d = S_FETCH;
                end
            end
            S_DRAIN: begin
                if (imem_ack) begin
                    state_d = S_FETCH;
                end
            end
            default: state_d = S_FETCH;
        endcase
    end

    // Request output. It drops at once in the reset cycle, so an in-flight fetch is abandoned.
    always_comb begin
        imem_req = 1'b0;
        if (!reset) begin
            case (state_q)
                S_FETCH: imem_req = !misaligned;
                S_DRAIN: imem_req = 1'b1;
                default: imem_req = 1'b0;
            endcase
        end
    end

    // Datapath next values: PC, redirect target, skid buffer and IF/ID latch.
    always_comb begin
        pc_d         = pc_q;
        redir_d      = redir_q;
        skid_instr_d = skid_instr_q;
        skid_exc_d   = skid_exc_q;
        id_valid_d   = id_valid_q;
        id_pc_d      = id_pc_q;
        id_instr_d   = id_instr_q;
        id_exc_d     = id_exc_q;
        case (state_q)
            S_FETCH: begin
                if (fetch_done) begin
                    if (flush) begin
                        pc_d         = npc_in;
                        skid_instr_d = 32'h0;
                        skid_exc_d   = 1'b0;
                        id_valid_d   = 1'b0;
                        id_pc_d      = 32'h0;
                        id_instr_d   = 32'h0;
                        id_exc_d     = 1'b0;
                    end else if (stall) begin
                        skid_instr_d = fetch_instr;
                        skid_exc_d   = fetch_exc;
                    end else begin
                        pc_d       = npc_in;
                        id_valid_d = 1'b1;
                        id_pc_d    = pc_q;
                        id_instr_d = fetch_instr;
                        id_exc_d   = fetch_exc;
                    end
                end else if (flush || !stall) begin
                    // A flush or a bubble both empty IF/ID. Only a flush arms the redirect.
                    if (flush) begin
                        redir_d = npc_in;
                    end
                    id_valid_d = 1'b0;
                    id_pc_d    = 32'h0;
                    id_instr_d = 32'h0;
                    id_exc_d   = 1'b0;
                end
            end
            S_HOLD: begin
                if (flush) begin
                    pc_d         = npc_in;
                    skid_instr_d = 32'h0;
                    skid_exc_d   = 1'b0;
                    id_valid_d   = 1'b0;
                    id_pc_d      = 32'h0;
                    id_instr_d   = 32'h0;
                    id_exc_d     = 1'b0;
                end else if (!stall) begin
                    pc_d       = npc_in;
                    id_valid_d = 1'b1;
                    id_pc_d    = pc_q;
                    id_instr_d = skid_instr_q;
                    id_exc_d   = skid_exc_q;
                end
            end
            S_DRAIN: begin
                if (flush) begin
                    redir_d = npc_in;
                end
                if (imem_ack) begin
                    pc_d = flush ? npc_in : redir_q;
                end
            end
            default: ;
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q         <= RESET_PC;
            redir_q      <= 32'h0;
            skid_instr_q <= 32'h0;
            skid_exc_q   <= 1'b0;
            id_valid_q   <= 1'b0;
            id_pc_q      <= 32'h0;
            id_instr_q   <= 32'h0;
            id_exc_q     <= 1'b0;
        end else begin
            pc_q         <= pc_d;
            redir_q      <= redir_d;
            skid_instr_q <= skid_instr_d;
            skid_exc_q   <= skid_exc_d;
            id_valid_q   <= id_valid_d;
            id_pc_q      <= id_pc_d;
            id_instr_q   <= id_instr_d;
            id_exc_q     <= id_exc_d;
        end
    end

endmodule

// File: tb/tb_ifu_fetch.sv
// Testbench for ifu_fetch: a per-cycle vector table, a delivery scoreboard, and
// hand-written reset and alignment sequences.
module tb_ifu_fetch;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] npc_in;
    logic        stall, flush;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] pc;
    logic        id_valid;
    logic [31:0] id_pc, id_instr;
    logic        id_exc_adel;

    logic        ovr_en;
    logic [31:0] ovr;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // Memory word model and next-PC source.
    function automatic logic [31:0] w(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    assign imem_rdata = w(imem_addr);
    assign npc_in     = ovr_en ? ovr : pc + 32'd4;

    ifu_fetch dut (
        .clk        (clk),
        .reset      (reset),
        .npc_in     (npc_in),
        .stall      (stall),
        .flush      (flush),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .pc         (pc),
        .id_valid   (id_valid),
        .id_pc      (id_pc),
        .id_instr   (id_instr),
        .id_exc_adel(id_exc_adel)
    );

    typedef struct {
        logic        stall;
        logic        flush;
        logic        ack;
        logic        ovr_en;
        logic [31:0] ovr;
        logic        e_req;
        logic [31:0] e_pc;
        logic        e_valid;
        logic [31:0] e_idpc;
        logic        push;
    } vec_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic add_v(input logic s, input logic f, input logic a, input logic oe,
                         input logic [31:0] o, input logic er, input logic [31:0] ep,
                         input logic ev, input logic [31:0] eid, input logic p);
        vec_t v;
        v.stall = s; v.flush = f; v.ack = a; v.ovr_en = oe; v.ovr = o;
        v.e_req = er; v.e_pc = ep; v.e_valid = ev; v.e_idpc = eid; v.push = p;
        vecs.push_back(v);
    endtask

    initial begin
        logic        prev_valid;
        logic [31:0] prev_pc;
        exp_t        e;

        // Cycle table. Expected imem_addr equals expected pc throughout.
        add_v(0,0,1,0,0,          1,32'h3000,0,32'h0,   1); // C0  first fetch
        add_v(0,0,1,0,0,          1,32'h3004,1,32'h3000,1); // C1
        add_v(0,0,1,0,0,          1,32'h3008,1,32'h3004,1); // C2
        add_v(0,0,0,0,0,          1,32'h300C,1,32'h3008,0); // C3  ack delayed
        add_v(0,0,0,0,0,          1,32'h300C,0,32'h0,   0); // C4
        add_v(0,0,0,0,0,          1,32'h300C,0,32'h0,   0); // C5
        add_v(0,0,1,0,0,          1,32'h300C,0,32'h0,   1); // C6  late ack
        add_v(1,0,1,0,0,          1,32'h3010,1,32'h300C,1); // C7  stall on ack -> skid
        add_v(1,0,0,0,0,          0,32'h3010,1,32'h300C,0); // C8  hold
        add_v(0,0,0,0,0,          0,32'h3010,1,32'h300C,0); // C9  release
        add_v(0,0,0,0,0,          1,32'h3014,1,32'h3010,0); // C10 no refetch
        add_v(0,1,0,1,32'h3100,   1,32'h3014,0,32'h0,   0); // C11 flush unacked
        add_v(0,0,0,0,0,          1,32'h3014,0,32'h0,   0); // C12 drain
        add_v(0,0,1,0,0,          1,32'h3014,0,32'h0,   0); // C13 drain ack, discard
        add_v(0,0,1,0,0,          1,32'h3100,0,32'h0,   1); // C14 redirected
        add_v(1,0,1,0,0,          1,32'h3104,1,32'h3100,0); // C15 skid, later flushed
        add_v(1,1,0,1,32'h3200,   0,32'h3104,1,32'h3100,0); // C16 flush+stall in HOLD
        add_v(0,0,1,0,0,          1,32'h3200,0,32'h0,   1); // C17
        add_v(0,1,0,1,32'h3300,   1,32'h3204,1,32'h3200,0); // C18 flush -> drain
        add_v(0,1,0,1,32'h3400,   1,32'h3204,0,32'h0,   0); // C19 reflush overwrites
        add_v(0,0,1,0,0,          1,32'h3204,0,32'h0,   0); // C20 drain ack
        add_v(0,0,1,0,0,          1,32'h3400,0,32'h0,   1); // C21
        add_v(1,0,0,0,0,          1,32'h3404,1,32'h3400,0); // C22 stall, no ack: hold
        add_v(0,0,0,0,0,          1,32'h3404,1,32'h3400,0); // C23 bubble
        add_v(0,0,0,0,0,          1,32'h3404,0,32'h0,   0); // C24
        add_v(0,1,1,1,32'h3500,   1,32'h3404,0,32'h0,   0); // C25 flush with ack
        add_v(0,0,1,0,0,          1,32'h3500,0,32'h0,   1); // C26
        add_v(0,0,0,0,0,          1,32'h3504,1,32'h3500,0); // C27

        reset = 1'b1; stall = 1'b0; flush = 1'b0; imem_ack = 1'b0;
        ovr_en = 1'b0; ovr = 32'h0;
        @(posedge clk); #1;
        chk("reset_req", 32'(imem_req), 32'h0);
        chk("reset_pc", pc, 32'h3000);
        chk("reset_valid", 32'(id_valid), 32'h0);
        chk("reset_idpc", id_pc, 32'h0);
        chk("reset_instr", id_instr, 32'h0);
        chk("reset_exc", 32'(id_exc_adel), 32'h0);
        reset = 1'b0;

        prev_valid = 1'b0;
        prev_pc    = 32'h0;
        for (int i = 0; i < vecs.size(); i++) begin
            stall    = vecs[i].stall;
            flush    = vecs[i].flush;
            imem_ack = vecs[i].ack;
            ovr_en   = vecs[i].ovr_en;
            ovr      = vecs[i].ovr;
            if (vecs[i].push) begin
                e.pc    = vecs[i].e_pc;
                e.instr = w(vecs[i].e_pc);
                sb.push_back(e);
            end
            @(negedge clk);
            chk($sformatf("v%0d_req", i), 32'(imem_req), 32'(vecs[i].e_req));
            chk($sformatf("v%0d_addr", i), imem_addr, vecs[i].e_pc);
            chk($sformatf("v%0d_pc", i), pc, vecs[i].e_pc);
            chk($sformatf("v%0d_valid", i), 32'(id_valid), 32'(vecs[i].e_valid));
            chk($sformatf("v%0d_idpc", i), id_pc, vecs[i].e_idpc);
            chk($sformatf("v%0d_instr", i), id_instr,
                vecs[i].e_valid ? w(vecs[i].e_idpc) : 32'h0);
            chk($sformatf("v%0d_exc", i), 32'(id_exc_adel), 32'h0);
            // Scoreboard: every newly latched instruction must match the oldest delivery.
            if (id_valid && (!prev_valid || id_pc != prev_pc)) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL sb_unexpected got_pc=%h exp=none", id_pc);
                end else begin
                    e = sb.pop_front();
                    chk($sformatf("sb%0d_pc", i), id_pc, e.pc);
                    chk($sformatf("sb%0d_instr", i), id_instr, e.instr);
                end
            end
            prev_valid = id_valid;
            prev_pc    = id_pc;
            @(posedge clk); #1;
        end
        chk("sb_leftover", 32'(sb.size()), 32'h0);

`ifdef FETCH_ALIGN_CHECK_EN
        // Misaligned PC: no request is issued, and the fetch completes as a nop with an exception.
        stall = 1'b0; flush = 1'b0; imem_ack = 1'b1; ovr_en = 1'b1; ovr = 32'h3602;
        @(posedge clk); #1;
        imem_ack = 1'b0; ovr_en = 1'b0;
        @(negedge clk);
        chk("adel_req", 32'(imem_req), 32'h0);
        chk("adel_pc", pc, 32'h3602);
        @(posedge clk); #1;
        @(negedge clk);
        chk("adel_valid", 32'(id_valid), 32'h1);
        chk("adel_exc", 32'(id_exc_adel), 32'h1);
        chk("adel_instr", id_instr, 32'h0);
        chk("adel_idpc", id_pc, 32'h3602);
        @(posedge clk); #1;
`endif

        // A reset while a fetch is outstanding drops the request immediately.
        stall = 1'b0; flush = 1'b0; imem_ack = 1'b0; ovr_en = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        chk("midreset_req", 32'(imem_req), 32'h0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("postreset_pc", pc, 32'h3000);
        chk("postreset_req", 32'(imem_req), 32'h1);
        chk("postreset_valid", 32'(id_valid), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ifu_fetch.md
# ifu_fetch

Instruction-fetch stage of the MIPS core. Holds the architectural PC register, issues word fetches to instruction memory over a req/ack handshake, and loads the IF/ID pipeline latch. Its `pc` output drives the next-PC logic, and the computed next PC returns on `npc_in`. It absorbs downstream stalls with a one-entry skid buffer and supports a redirecting flush while a fetch is outstanding.

## Interface
- `RESET_PC`, default 32'h0000_3000: PC value loaded on reset.
- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `npc_in`  in  32  next PC, combinationally derived from `pc`; also the redirect target when `flush`=1.
- `stall`  in  1  ID stage cannot accept; IF/ID latch must hold.
- `flush`  in  1  discard the IF/ID contents and any in-flight fetch, then redirect to `npc_in`.
- `imem_req`  out  1  fetch request.
- `imem_addr`  out  32  word address of the fetch.
- `imem_ack`  in  1  `imem_rdata` is valid this cycle.
- `imem_rdata`  in  32  instruction word.
- `pc`  out  32  current fetch PC.
- `id_valid`  out  1  IF/ID latch holds a real instruction.
- `id_pc`  out  32  PC of the latched instruction.
- `id_instr`  out  32  latched instruction; 0 (nop) when `id_valid`=0.
- `id_exc_adel`  out  1  the latched instruction had a misaligned PC (only meaningful under `FETCH_ALIGN_CHECK_EN`).

## Operation
- FSM states:
  - FETCH: `imem_req`=1, `imem_addr`=`pc`.
  - HOLD: word is in the skid buffer, `imem_req`=0.
  - DRAIN: a flushed fetch is still outstanding; `imem_req`=1 and the address is held.
- FETCH with ack and no stall: load IF/ID with {`pc`, `imem_rdata`} and set `id_valid`=1; `pc`<=`npc_in`; stay in FETCH.
- FETCH with ack and stall: capture `imem_rdata` into the skid buffer; IF/ID holds; `pc` holds; go to HOLD.
- FETCH with no ack: `pc` holds. If there is no stall, `id_valid`<=0 (bubble). If there is a stall, IF/ID holds.
- HOLD: while `stall` stays high, everything holds. When `stall`=0, load IF/ID from the skid buffer, `pc`<=`npc_in`, go to FETCH.
- Request rule: once `imem_req` rises, `imem_addr` stays stable until the ack cycle. Requests are never withdrawn except by `reset`.
- `flush` (takes priority over `stall`) clears `id_valid` and drops the skid buffer.
  - FETCH with ack, or HOLD: `pc`<=`npc_in`; go to FETCH.
  - FETCH without ack: latch `npc_in` into a redirect register; go to DRAIN.
- DRAIN:
  - On ack: discard the data, `pc`<=redirect register, go to FETCH.
  - A further flush while in DRAIN overwrites the redirect register.
- Width rule: `pc` advances only via `npc_in`. This block does no PC arithmetic of its own.

## Timing
- Reset values:
  - `pc`=`RESET_PC`, state FETCH.
  - `imem_req`=0 during the reset cycle, then 1 on the first cycle after reset.
  - `id_valid`=0, `id_pc`=0, `id_instr`=0, `id_exc_adel`=0; skid buffer empty.
- `imem_ack` is sampled at the rising edge. Ack may be asserted in the first request cycle, which gives 1-cycle latency.
- With `imem_ack` tied high, throughput is one instruction per cycle, and IF/ID shows the instruction one cycle after its address appears on `imem_addr`.
- A stall that starts in the same cycle as an ack costs no refetch: the instruction is held in the skid buffer.
- `reset` asserted mid-fetch or in DRAIN aborts immediately. The memory must tolerate the dropped request.

## Configuration
- `FETCH_ALIGN_CHECK_EN` defined:
  - In FETCH, if `pc[1:0]`≠0, no request is issued (`imem_req`=0).
  - The fetch completes internally as if acked, with instruction 0 and `id_exc_adel`=1 latched alongside `id_pc`=`pc`. Stall, skid and flush rules are unchanged.
- `FETCH_ALIGN_CHECK_EN` undefined:
  - `imem_addr`={`pc[31:2]`,2'b00}.
  - `id_exc_adel` is tied to 0.

## Test plan
- Reset, then `imem_ack`=1 and `npc_in`=`pc`+4: `imem_addr` steps 0x3000, 0x3004, 0x3008 on consecutive cycles; `id_pc` trails by one cycle; `id_valid`=1 from the second cycle after reset.
- Ack delayed 3 cycles at 0x3004: `imem_addr` is stable for all 3 cycles; `id_valid`=0 for those cycles; `id_instr` is then the acked word.
- `stall`=1 on the ack cycle of 0x3008 for 2 cycles: IF/ID holds 0x3004, `imem_req`=0, and `pc` stays 0x3008. When the stall releases, IF/ID shows 0x3008 with no extra memory request.
- `flush`=1 with `npc_in`=0x3100 while a fetch of 0x300C is unacked: the 0x300C data is discarded on its ack; the next `imem_addr` is 0x3100; `id_valid`=0 through the drain.
- `flush` and `stall` together in HOLD: the flush wins; `pc`<=`npc_in`; `id_valid`=0.
- `FETCH_ALIGN_CHECK_EN` with `npc_in`=0x3002: `imem_req`=0 for that PC; the next cycle shows `id_valid`=1, `id_exc_adel`=1, `id_instr`=0, `id_pc`=0x3002.
